// File: rtl/uart_receiver.sv
// uart_receiver: serial receive framer. Recovers 5..8 bit characters from the
// synchronized line using the 16x enable tick. It checks parity and the first
// stop bit, then pushes {break, pe, fe, data} into the RX FIFO with a one-clk
// strobe.
// Optional feature macro: UART_RX_BREAK_DET_EN (break counter and break flag).
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int BRK_TICKS   = 176
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic [7:0]  lcr,
  input  logic        enable,
  input  logic        srx_pad_i,
  input  logic        rx_reset,
  output logic        rf_push,
  output logic [10:0] rf_data,
  output logic        rf_break_o,
  output logic [2:0]  rstate
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC_START  = 3'd1,
    S_REC_BIT    = 3'd2,
    S_REC_PARITY = 3'd3,
    S_REC_STOP   = 3'd4,
    S_PUSH       = 3'd5
  } rx_state_t;

  rx_state_t              state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srx_s;
  logic [3:0]             cnt, cnt_n;
  logic [2:0]             bc, bc_n;
  logic [7:0]             data, data_n;
  logic                   par_err, par_err_n;
  logic                   fr_err, fr_err_n;
  logic                   armed, armed_n;
  logic                   push_n;
  logic [10:0]            rf_data_n;
  logic [2:0]             last_bc;
  logic [7:0]             len_mask;
  logic                   par_x, par_exp;

  assign srx_s    = sync_q[SYNC_STAGES-1];
  assign last_bc  = {1'b0, lcr[1:0]} + 3'd4;
  assign len_mask = 8'hFF >> (2'd3 - lcr[1:0]);
  assign par_x    = ^(data & len_mask);
  assign rstate   = state;

  // Expected parity bit from {EP,SP}: odd, stick-1, even, stick-0.
  always_comb begin
    par_exp = ~par_x;
    case ({lcr[4], lcr[5]})
      2'b00:   par_exp = ~par_x;
      2'b01:   par_exp = 1'b1;
      2'b10:   par_exp = par_x;
      default: par_exp = 1'b0;
    endcase
  end

  // Line synchronizer; flops idle high like the line.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], srx_pad_i};
  end

  // Next-state and datapath decode; rx_reset overrides everything at the end.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bc_n      = bc;
    data_n    = data;
    par_err_n = par_err;
    fr_err_n  = fr_err;
    armed_n   = armed;
    push_n    = 1'b0;
    rf_data_n = rf_data;
    // Any tick that sees the line high re-arms start detection; this is also
    // what keeps a stuck-low line from restarting after a framing error.
    if (enable && srx_s) armed_n = 1'b1;
    case (state)
      S_IDLE: begin
        if (enable && armed && !srx_s) begin
          cnt_n     = 4'd7;
          data_n    = 8'h00;
          par_err_n = 1'b0;
          fr_err_n  = 1'b0;
          state_n   = S_REC_START;
        end
      end
      S_REC_START: begin
        if (enable) begin
          if (cnt != 4'd0)  cnt_n = cnt - 4'd1;
          else if (!srx_s) begin
            cnt_n   = 4'd15;
            bc_n    = 3'd0;
            state_n = S_REC_BIT;
          end else          state_n = S_IDLE;
        end
      end
      S_REC_BIT: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            data_n[bc] = srx_s;
            cnt_n      = 4'd15;
            // bc wraps if lcr shrinks mid-frame, so this always terminates
            if (bc == last_bc) state_n = lcr[3] ? S_REC_PARITY : S_REC_STOP;
            else               bc_n    = bc + 3'd1;
          end
        end
      end
      S_REC_PARITY: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            par_err_n = (srx_s != par_exp);
            cnt_n     = 4'd15;
            state_n   = S_REC_STOP;
          end
        end
      end
      S_REC_STOP: begin
        if (enable) begin
          if (cnt != 4'd0) cnt_n = cnt - 4'd1;
          else begin
            fr_err_n = ~srx_s;
            state_n  = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        push_n    = 1'b1;
        rf_data_n = {rf_break_o, par_err, fr_err, data & len_mask};
        armed_n   = 1'b0;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (rx_reset) begin
      state_n   = S_IDLE;
      cnt_n     = 4'd0;
      bc_n      = 3'd0;
      armed_n   = 1'b0;
      push_n    = 1'b0;
      rf_data_n = rf_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      bc      <= 3'd0;
      data    <= 8'h00;
      par_err <= 1'b0;
      fr_err  <= 1'b0;
      armed   <= 1'b0;
      rf_push <= 1'b0;
      rf_data <= 11'h000;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bc      <= bc_n;
      data    <= data_n;
      par_err <= par_err_n;
      fr_err  <= fr_err_n;
      armed   <= armed_n;
      rf_push <= push_n;
      rf_data <= rf_data_n;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  localparam int BW = $clog2(BRK_TICKS + 1);
  localparam logic [BW-1:0] BRK_MAX = BW'(BRK_TICKS);

  logic [BW-1:0] brk_cnt;

  // Count consecutive low ticks; flag the break when the count saturates.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      brk_cnt    <= '0;
      rf_break_o <= 1'b0;
    end else if (enable) begin
      if (srx_s) begin
        brk_cnt    <= '0;
        rf_break_o <= 1'b0;
      end else if (brk_cnt != BRK_MAX) begin
        brk_cnt <= brk_cnt + 1'b1;
        if (brk_cnt == BRK_MAX - 1'b1) rf_break_o <= 1'b1;
      end
    end
  end
`else
  logic brk_unused;
  assign brk_unused = (BRK_TICKS > 0);
  assign rf_break_o = 1'b0;
`endif

  logic lcr_unused;
  assign lcr_unused = ^{lcr[7:6], lcr[2]};

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random and directed frames driven tick-by-tick; expected
// FIFO words come from a frame-level model queued before each frame is sent.
module tb_uart_receiver;
  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  lcr = 8'h03;
  logic        enable = 1'b0;
  logic        srx_pad_i = 1'b1;
  logic        rx_reset = 1'b0;
  logic        rf_push;
  logic [10:0] rf_data;
  logic        rf_break_o;
  logic [2:0]  rstate;

  int n_chk = 0, n_fail = 0, n_push = 0, n_start = 0, n_exp = 0;
  int tick_div = 16;
  logic [10:0] exp_q[$];
  logic [1:0]  en_h = 2'b00;

  uart_receiver dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .lcr(lcr), .enable(enable),
    .srx_pad_i(srx_pad_i), .rx_reset(rx_reset), .rf_push(rf_push),
    .rf_data(rf_data), .rf_break_o(rf_break_o), .rstate(rstate)
  );

  always #5 clk = ~clk;

  // 16x tick: one clk wide every tick_div clocks
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c = (c + 1 >= tick_div) ? 0 : c + 1;
      enable = (c == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push monitor: scoreboard compare and push-latency check.
  always @(negedge clk) begin
    if (rf_push) begin
      n_push <= n_push + 1;
      chk("push_latency", {31'd0, en_h[1]}, 32'd1);
      if (exp_q.size() == 0) chk("spurious_push", {31'd0, rf_push}, 32'd0);
      else                   chk("rf_data", {21'd0, rf_data}, {21'd0, exp_q.pop_front()});
    end
    if (rstate == 3'd1) n_start <= n_start + 1;
    en_h <= {en_h[0], enable};
  end

  // wait for n enable ticks to be consumed, then step off the edge
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!enable) @(posedge clk);
    end
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    srx_pad_i = v;
    ticks(n);
  endtask

  function automatic logic par_of(input logic [7:0] l, input logic [7:0] d);
    int nb;
    logic x;
    nb = int'(l[1:0]) + 5;
    x = 1'b0;
    for (int i = 0; i < nb; i++) x ^= d[i];
    case ({l[4], l[5]})
      2'b00:   return ~x;
      2'b01:   return 1'b1;
      2'b10:   return x;
      default: return 1'b0;
    endcase
  endfunction

  // One frame: start, data LSB first, optional parity (flipped on request),
  // one stop bit of the given value, then `gap` idle ticks.
  task automatic send(input logic [7:0] l, input logic [7:0] d, input bit flip,
                      input bit stop, input int gap);
    int nb;
    logic [7:0] m;
    nb = int'(l[1:0]) + 5;
    m  = d & 8'((9'h100 >> (8 - nb)) - 9'd1);
    lcr = l;
    exp_q.push_back({1'b0, l[3] & flip, ~stop, m});
    n_exp++;
    hold(1'b0, 16);
    for (int i = 0; i < nb; i++) hold(m[i], 16);
    if (l[3]) hold(par_of(l, m) ^ flip, 16);
    hold(stop, 16);
    hold(1'b1, gap);
  endtask

  initial begin
    int p, s;
    logic [7:0] l, d;
    bit fl, st;
    int g;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_push", {31'd0, rf_push}, 32'd0);
    chk("rst_data", {21'd0, rf_data}, 32'd0);
    chk("rst_break", {31'd0, rf_break_o}, 32'd0);
    chk("rst_state", {29'd0, rstate}, 32'd0);
    wb_rst_i = 1'b0;
    ticks(3);

    // 8N1 0xA5 at 16 clk per tick
    send(8'h03, 8'hA5, 1'b0, 1'b1, 4);
    chk("a5_state", {29'd0, rstate}, 32'd0);
    chk("a5_npush", n_push, 32'd1);

    tick_div = 4;
    ticks(2);

    // 7E1 0x41 with the parity bit inverted
    send(8'h1A, 8'h41, 1'b1, 1'b1, 4);

    // short low glitch: start seen, false start, no push
    p = n_push; s = n_start;
    hold(1'b0, 4);
    hold(1'b1, 20);
    chk("glitch_start", {31'd0, n_start > s}, 32'd1);
    chk("glitch_nopush", n_push, p);
    chk("glitch_state", {29'd0, rstate}, 32'd0);

    // framing error, line stays low: one push only, no restart
    send(8'h03, 8'h3C, 1'b0, 1'b0, 0);
    p = n_push;
    hold(1'b0, 40);
    chk("stuck_nopush", n_push, p);
    chk("stuck_state", {29'd0, rstate}, 32'd0);
    hold(1'b1, 2);
    send(8'h03, 8'h96, 1'b0, 1'b1, 2);

    // rx_reset aborts a frame in progress
    lcr = 8'h03;
    hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 8);
    @(negedge clk) rx_reset = 1'b1;
    @(negedge clk) rx_reset = 1'b0;
    #1;
    chk("rxrst_state", {29'd0, rstate}, 32'd0);
    p = n_push;
    hold(1'b1, 40);
    chk("rxrst_nopush", n_push, p);

    // wb_rst_i during bit 3
    hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 8);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_state", {29'd0, rstate}, 32'd0);
    chk("mid_rst_data", {21'd0, rf_data}, 32'd0);
    chk("mid_rst_push", {31'd0, rf_push}, 32'd0);
    p = n_push;
    @(negedge clk) wb_rst_i = 1'b0;
    hold(1'b1, 20);
    chk("mid_rst_nopush", n_push, p);
    send(8'h03, 8'h55, 1'b0, 1'b1, 3);

`ifdef UART_RX_BREAK_DET_EN
    // long low: one 0x00/fe push (frame ends before saturation), then break
    lcr = 8'h03;
    exp_q.push_back(11'h100);
    n_exp++;
    hold(1'b0, 175);
    chk("brk_before", {31'd0, rf_break_o}, 32'd0);
    hold(1'b0, 25);
    chk("brk_active", {31'd0, rf_break_o}, 32'd1);
    hold(1'b1, 1);
    chk("brk_clear", {31'd0, rf_break_o}, 32'd0);
    hold(1'b1, 3);
`endif

    // random frames, including back-to-back and framing errors
    for (int k = 0; k < 30; k++) begin
      l  = 8'($urandom) & 8'h3F;
      d  = 8'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      if (!st) d[0] = 1'b1;
      g  = st ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      send(l, d, fl, st, g);
    end
    hold(1'b1, 4);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("push_total", n_push, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
